sev_scan_capture: RTL and testbench

//  Reader end of the multiplexed 7-segment display bus: samples scanned anode/segment pins and

---
 rtl/sev_scan_capture_if.sv | 22 ++
 rtl/sev_scan_capture.sv | 113 +++++++++++
 tb/tb_sev_scan_capture.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/sev_scan_capture_if.sv
// sev_scan_capture_if: scanned 7-segment pins in, rebuilt digits and event pulses out
interface sev_scan_capture_if #(
    parameter int DIGITS = 4
);
    logic [DIGITS-1:0]   an;
    logic [6:0]          seg;
    logic [4*DIGITS-1:0] value;
    logic [DIGITS-1:0]   digit_valid;
    logic                frame_done;
    logic                bad_pattern;
    logic                an_conflict;

    modport master (
        output an, seg,
        input  value, digit_valid, frame_done, bad_pattern, an_conflict
    );

    modport slave (
        input  an, seg,
        output value, digit_valid, frame_done, bad_pattern, an_conflict
    );
endinterface

// File: rtl/sev_scan_capture.sv
// sev_scan_capture: samples a multiplexed active-low 7-segment bus and rebuilds each digit's nibble
module sev_scan_capture #(
    parameter int DIGITS        = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    sev_scan_capture_if.slave bus
);
    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam int SW = DIGITS + 7;

    logic [SW-1:0]       s1_q, s2_q, prev_q;
    logic [1:0]          warm_q;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                cap_q, cap_d;
    logic [4*DIGITS-1:0] value_q, value_d;
    logic [DIGITS-1:0]   valid_q, valid_d, seen_q, seen_d, an_l;
    logic                frame_q, frame_d, bad_q, bad_d, conf_q, conf_d;
    logic                live, same, fire, one_hot;
    logic [4:0]          dec;

    function automatic logic [4:0] decode(input logic [6:0] s);
        case (s)
            7'b0000001: return 5'h10;
            7'b1001111: return 5'h11;
            7'b0010010: return 5'h12;
            7'b0000110: return 5'h13;
            7'b1001100: return 5'h14;
            7'b0100100: return 5'h15;
            7'b0100000: return 5'h16;
            7'b0001111: return 5'h17;
            7'b0000000: return 5'h18;
            7'b0000100: return 5'h19;
            7'b0001000: return 5'h1A;
            7'b1100000: return 5'h1B;
            7'b0110001: return 5'h1C;
            7'b1000010: return 5'h1D;
            7'b0110000: return 5'h1E;
            7'b0111000: return 5'h1F;
            default:    return 5'h00;
        endcase
    endfunction

    // The synchronizer still holds reset values for two cycles; treat those as no sample.
    always_comb begin
        live    = warm_q == 2'd2;
        same    = live && s2_q == prev_q;
        cnt_d   = !live ? '0 : !same ? CW'(1) :
                  cnt_q == CW'(STABLE_CYCLES) ? cnt_q : cnt_q + CW'(1);
        fire    = live && cnt_d == CW'(STABLE_CYCLES) && !(cap_q && same);
        cap_d   = fire || (cap_q && same);
        an_l    = ~s2_q[SW-1:7];
        one_hot = an_l != '0 && (an_l & (an_l - DIGITS'(1))) == '0;
        dec     = decode(s2_q[6:0]);
        value_d = value_q;
        valid_d = valid_q;
        seen_d  = seen_q;
        frame_d = 1'b0;
        bad_d   = 1'b0;
        conf_d  = fire && an_l != '0 && !one_hot;
        if (fire && one_hot) begin
            bad_d = !dec[4];
            for (int i = 0; i < DIGITS; i++) begin
                if (an_l[i]) begin
                    if (dec[4]) value_d[4*i +: 4] = dec[3:0];
                    valid_d[i] = dec[4];
                    seen_d[i]  = 1'b1;
                end
            end
            if (&seen_d) begin
                frame_d = 1'b1;
                seen_d  = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q    <= '0;
            s2_q    <= '0;
            prev_q  <= '0;
            warm_q  <= '0;
            cnt_q   <= '0;
            cap_q   <= 1'b0;
            value_q <= '0;
            valid_q <= '0;
            seen_q  <= '0;
            frame_q <= 1'b0;
            bad_q   <= 1'b0;
            conf_q  <= 1'b0;
        end else begin
            s1_q    <= {bus.an, bus.seg};
            s2_q    <= s1_q;
            prev_q  <= s2_q;
            warm_q  <= live ? warm_q : warm_q + 2'd1;
            cnt_q   <= cnt_d;
            cap_q   <= cap_d;
            value_q <= value_d;
            valid_q <= valid_d;
            seen_q  <= seen_d;
            frame_q <= frame_d;
            bad_q   <= bad_d;
            conf_q  <= conf_d;
        end
    end

    assign bus.value       = value_q;
    assign bus.digit_valid = valid_q;
    assign bus.frame_done  = frame_q;
    assign bus.bad_pattern = bad_q;
    assign bus.an_conflict = conf_q;
endmodule

// File: tb/tb_sev_scan_capture.sv
// tb_sev_scan_capture: scoreboard bench; each stable dwell predicts its capture event and cycle
module tb_sev_scan_capture;
    localparam int DIGITS = 4;
    localparam int S      = 4;

    typedef struct {
        int          cyc;
        logic [15:0] value;
        logic [3:0]  valid;
        logic        frame, bad, conf;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    exp_t        exp_q[$];
    exp_t        got_e;
    logic [15:0] m_val, last_val;
    logic [3:0]  m_vld, m_seen, last_vld;
    logic [6:0]  codes [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                                7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                                7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

    sev_scan_capture_if #(.DIGITS(DIGITS)) bus ();

    sev_scan_capture #(.DIGITS(DIGITS), .STABLE_CYCLES(S)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    function automatic bit legal_code(input logic [6:0] s);
        for (int j = 0; j < 16; j++) if (codes[j] == s) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_val  = '0;
        m_vld  = '0;
        m_seen = '0;
    endtask

    task automatic predict(input logic [3:0] an, input logic [6:0] seg, input int at);
        logic [3:0]  an_l, vld, seen, nib;
        logic [15:0] val;
        exp_t        e;
        int          idx;
        bit          legal;
        an_l = ~an;
        if (an_l == 4'h0) return;
        e.cyc = at; e.frame = 1'b0; e.bad = 1'b0; e.conf = 1'b0;
        if ($countones(an_l) > 1) begin
            e.value = m_val; e.valid = m_vld; e.conf = 1'b1;
            exp_q.push_back(e);
            return;
        end
        legal = 1'b0; nib = 4'h0; idx = 0;
        for (int j = 0; j < 16; j++) if (codes[j] == seg) begin legal = 1'b1; nib = 4'(j); end
        for (int i = 0; i < 4; i++) if (an_l[i]) idx = i;
        val = m_val; vld = m_vld; seen = m_seen | (4'b1 << idx);
        if (legal) begin
            val[4*idx +: 4] = nib;
            vld[idx] = 1'b1;
        end else begin
            vld[idx] = 1'b0;
            e.bad = 1'b1;
        end
        if (seen == 4'hF) begin e.frame = 1'b1; seen = 4'h0; end
        e.value = val; e.valid = vld;
        if (e.bad || e.frame || val != m_val || vld != m_vld) exp_q.push_back(e);
        m_val = val; m_vld = vld; m_seen = seen;
    endtask

    // Pins change 1 time unit after an edge, so the next edge is the first to sample them.
    task automatic dwell(input logic [3:0] an, input logic [6:0] seg, input int len);
        @(posedge clk); #1;
        bus.an  = an;
        bus.seg = seg;
        if (len >= S) predict(an, seg, cyc + S + 2);
        repeat (len - 1) @(posedge clk);
    endtask

    task automatic quiet(input string tag);
        repeat (S + 4) @(posedge clk);
        #2;
        chk({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
        chk({tag, "_value"}, 32'(bus.value), 32'(m_val));
        chk({tag, "_valid"}, 32'(bus.digit_valid), 32'(m_vld));
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            last_val = bus.value;
            last_vld = bus.digit_valid;
        end else begin
            if (bus.frame_done || bus.bad_pattern || bus.an_conflict ||
                bus.value !== last_val || bus.digit_valid !== last_vld) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_pulses", 32'({bus.frame_done, bus.bad_pattern, bus.an_conflict}), 32'd0);
                    chk("spurious_outputs", 32'({bus.digit_valid, bus.value}), 32'({last_vld, last_val}));
                end else begin
                    got_e = exp_q.pop_front();
                    chk("capture_cycle", 32'(cyc), 32'(got_e.cyc));
                    chk("value", 32'(bus.value), 32'(got_e.value));
                    chk("digit_valid", 32'(bus.digit_valid), 32'(got_e.valid));
                    chk("frame_done", 32'(bus.frame_done), 32'(got_e.frame));
                    chk("bad_pattern", 32'(bus.bad_pattern), 32'(got_e.bad));
                    chk("an_conflict", 32'(bus.an_conflict), 32'(got_e.conf));
                end
            end
            last_val = bus.value;
            last_vld = bus.digit_valid;
        end
    end

    initial begin
        int off;
        bus.an  = '1;
        bus.seg = '1;
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // T1: capture something, then reset in the middle of the next dwell
        dwell(4'b1110, codes[2], 6);
        dwell(4'b1101, codes[5], 2);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("rst_value", 32'(bus.value), 32'd0);
        chk("rst_valid", 32'(bus.digit_valid), 32'd0);
        chk("rst_frame", 32'(bus.frame_done), 32'd0);
        chk("rst_bad", 32'(bus.bad_pattern), 32'd0);
        chk("rst_conf", 32'(bus.an_conflict), 32'd0);
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        predict(4'b1101, codes[5], cyc + S + 2);
        repeat (9) @(posedge clk);
        quiet("t1");

        // T2: latency and single capture over a long dwell
        dwell(4'b1110, 7'b0010010, 100);
        quiet("t2");

        // T3: full frame 3,A,B,F
        dwell(4'b1110, codes[3], 6);
        dwell(4'b1101, codes[10], 6);
        dwell(4'b1011, codes[11], 6);
        dwell(4'b0111, codes[15], 6);
        quiet("t3");
        chk("t3_frame_value", 32'(bus.value), 32'h0000FBA3);
        chk("t3_frame_valid", 32'(bus.digit_valid), 32'hF);

        // T4: illegal pattern keeps old nibble but still counts toward the frame
        dwell(4'b1101, codes[5], 6);
        dwell(4'b1101, 7'b1111110, 6);
        dwell(4'b1110, codes[1], 6);
        dwell(4'b1011, codes[7], 6);
        dwell(4'b0111, codes[9], 6);
        quiet("t4");

        // T5: glitching segments, anode conflict, blank
        for (int i = 0; i < 10; i++) dwell(4'b1110, (i % 2) ? codes[8] : codes[0], 2);
        dwell(4'b1100, codes[3], 6);
        dwell(4'b1111, codes[3], 6);
        quiet("t5");

        // T6: every legal code, then every illegal code from a random start
        for (int j = 0; j < 16; j++) dwell(4'b1110, codes[j], 6);
        off = int'($urandom_range(0, 127));
        for (int k = 0; k < 128; k++) begin
            logic [6:0] c;
            c = 7'((k + off) % 128);
            if (!legal_code(c)) dwell(4'b1110, c, 6);
        end
        dwell(4'b1101, codes[1], 6);
        dwell(4'b1011, codes[2], 6);
        dwell(4'b0111, 7'b1111111, 6);
        quiet("t6");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
